// File: rtl/set_bit_enumerator.sv
// set_bit_enumerator: walks a WIDTH-bit mask and emits the index of every set bit,
// one beat per cycle, LSB-first or MSB-first as chosen per word.
module set_bit_enumerator #(
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_high,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_none
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] lo_idx, hi_idx;
    logic             accept, beat;

    if (WIDTH < 2) begin : g_bad_width
        $error("set_bit_enumerator: WIDTH must be >= 2");
    end

    // Loops only span real bit positions, so padding indices can never be produced.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (pending_q[i]) lo_idx = IDX_W'(i);
        for (int i = 0; i < WIDTH; i++) if (pending_q[i]) hi_idx = IDX_W'(i);
    end

    assign out_valid = state_q == EMIT;
    assign out_index = mode_q ? hi_idx : lo_idx;
    assign out_none  = pending_q == '0;
    assign out_last  = (pending_q & (pending_q - WIDTH'(1))) == '0;
    assign in_ready  = !rst && (state_q == IDLE || (out_valid && out_ready && out_last));
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

    // A new word accepted on the last beat overrides the return to IDLE.
    always_comb begin
        pending_d = accept ? in_data : beat ? pending_q & ~(WIDTH'(1) << out_index) : pending_q;
        mode_d    = accept ? in_high : mode_q;
        state_d   = accept ? EMIT : (beat && out_last) ? IDLE : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
        end
    end
endmodule

// File: tb/tb_set_bit_enumerator.sv
// tb_set_bit_enumerator: directed scenarios plus scoreboard-checked random traffic
// on a WIDTH=32 and a WIDTH=13 instance.
module tb_set_bit_enumerator;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_high = 1'b0, out_ready = 1'b0, sel13 = 1'b0;
    logic [31:0] in_data = '0;
    logic        rdy32, ov32, last32, none32, rdy13, ov13, last13, none13;
    logic [4:0]  idx32;
    logic [3:0]  idx13;
    logic        rdy, ov, last, none;
    int          idx;
    int          checks = 0, errors = 0;

    typedef struct {int idx; bit last; bit none;} beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    set_bit_enumerator #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel13), .in_ready(rdy32),
        .in_data(in_data), .in_high(in_high), .out_valid(ov32), .out_ready(out_ready && !sel13),
        .out_index(idx32), .out_last(last32), .out_none(none32)
    );

    set_bit_enumerator #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel13), .in_ready(rdy13),
        .in_data(in_data[12:0]), .in_high(in_high), .out_valid(ov13), .out_ready(out_ready && sel13),
        .out_index(idx13), .out_last(last13), .out_none(none13)
    );

    always_comb begin
        rdy  = sel13 ? rdy13 : rdy32;
        ov   = sel13 ? ov13 : ov32;
        last = sel13 ? last13 : last32;
        none = sel13 ? none13 : none32;
        idx  = sel13 ? int'(idx13) : int'(idx32);
    end

    function automatic void push_word(input logic [31:0] w, input bit h, input int width);
        int n = $countones(w);
        int k = 0;
        if (w == 0) exp_q.push_back('{0, 1'b1, 1'b1});
        for (int j = 0; j < width; j++) begin
            int b = h ? width - 1 - j : j;
            if (w[b]) begin
                k++;
                exp_q.push_back('{b, k == n, 1'b0});
            end
        end
    endfunction

    task automatic send(input logic [31:0] w, input bit h);
        bit ok = 0;
        @(negedge clk);
        in_data = w; in_high = h; in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            #1;
            if (rdy === 1'b1) ok = 1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_accept in_ready=%0b required 1", rdy); end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 checks += 2;
        if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", ov); end
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b required 0", rdy); end
        rst = 1'b0;
        #1 checks++;
        if (rdy !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL release_idle in_ready=%0b out_valid=%0b required 1 0", rdy, ov); end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(32'h0, 1'b0);
        @(negedge clk); #1 checks++;
        if (ov !== 1'b1 || none !== 1'b1 || last !== 1'b1 || idx != 0)
            begin errors++; $display("FAIL zero_beat valid=%0b none=%0b last=%0b idx=%0d required 1 1 1 0", ov, none, last, idx); end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL zero_done out_valid=%0b in_ready=%0b required 0 1", ov, rdy); end
    endtask

    task automatic test_order();
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            send(32'h8000_0001, m[0]);
            for (int i = 0; i < 2; i++) begin
                int e = (m == 1) ? (i == 0 ? 31 : 0) : (i == 0 ? 0 : 31);
                @(negedge clk); #1 checks++;
                if (ov !== 1'b1 || idx != e || last !== (i == 1) || none !== 1'b0)
                    begin errors++; $display("FAIL order_m%0d_b%0d valid=%0b idx=%0d last=%0b required 1 %0d %0b", m, i, ov, idx, last, e, i == 1); end
                @(posedge clk);
            end
            @(negedge clk); #1 checks++;
            if (ov !== 1'b0) begin errors++; $display("FAIL order_m%0d_end out_valid=%0b required 0", m, ov); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(32'h0000_00F0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1 checks++;
            if (ov !== 1'b1 || idx != 4 || last !== 1'b0)
                begin errors++; $display("FAIL stall_c%0d valid=%0b idx=%0d last=%0b required 1 4 0", c, ov, idx, last); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1 checks++;
            if (ov !== 1'b1 || idx != 4 + i || last !== (i == 3))
                begin errors++; $display("FAIL stall_b%0d valid=%0b idx=%0d last=%0b required 1 %0d %0b", i, ov, idx, last, 4 + i, i == 3); end
        end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL stall_end out_valid=%0b required 0", ov); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        in_data = 32'h3; in_high = 1'b0; in_valid = 1'b1;
        #1 checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %0b required 1", rdy); end
        @(posedge clk);
        #1 in_data = 32'h4;
        @(negedge clk); #1 checks++;
        if (ov !== 1'b1 || idx != 0 || last !== 1'b0 || rdy !== 1'b0)
            begin errors++; $display("FAIL b2b_beat0 valid=%0b idx=%0d last=%0b in_ready=%0b required 1 0 0 0", ov, idx, last, rdy); end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b1 || idx != 1 || last !== 1'b1 || rdy !== 1'b1)
            begin errors++; $display("FAIL b2b_beat1 valid=%0b idx=%0d last=%0b in_ready=%0b required 1 1 1 1", ov, idx, last, rdy); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); #1 checks++;
        if (ov !== 1'b1 || idx != 2 || last !== 1'b1)
            begin errors++; $display("FAIL b2b_beat2 valid=%0b idx=%0d last=%0b required 1 2 1", ov, idx, last); end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid=%0b required 0", ov); end
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b1;
        send(32'h0000_0F00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1 checks++;
            if (ov !== 1'b1 || idx != 8 + i)
                begin errors++; $display("FAIL midrst_b%0d valid=%0b idx=%0d required 1 %0d", i, ov, idx, 8 + i); end
            @(posedge clk);
        end
        #1 rst = 1'b1;
        #1 checks++;
        if (ov !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL midrst_async out_valid=%0b in_ready=%0b required 0 0", ov, rdy); end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL midrst_held out_valid=%0b required 0", ov); end
        @(negedge clk);
        rst = 1'b0;
        #1 checks++;
        if (rdy !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL midrst_release in_ready=%0b out_valid=%0b required 1 0", rdy, ov); end
        @(negedge clk); #1 checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL midrst_stale out_valid=%0b required 0", ov); end
    endtask

    task automatic test_random(input int width, input int nwords, input bit s13);
        int          sent = 0, cyc = 0;
        bit          acc = 0, bt = 0;
        logic [31:0] mask = (width == 32) ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
        sel13 = s13;
        exp_q.delete();
        @(negedge clk);
        while ((sent < nwords || in_valid || exp_q.size() > 0) && cyc < 40000) begin
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < nwords && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 5))
                    0: in_data = 32'h0;
                    1: in_data = $urandom & $urandom & $urandom;
                    2: in_data = 32'd1 << $urandom_range(0, width - 1);
                    default: in_data = $urandom;
                endcase
                in_data &= mask;
                in_high = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                sent++;
            end
            out_ready = $urandom_range(0, 3) != 0;
            #1 checks++;
            if (ov !== (exp_q.size() > 0))
                begin errors++; $display("FAIL rand%0d_valid out_valid=%0b required %0b", width, ov, exp_q.size() > 0); end
            else if (ov && (idx != exp_q[0].idx || last !== exp_q[0].last || none !== exp_q[0].none))
                begin errors++; $display("FAIL rand%0d_beat idx=%0d last=%0b none=%0b required %0d %0b %0b", width, idx, last, none, exp_q[0].idx, exp_q[0].last, exp_q[0].none); end
            acc = in_valid && rdy;
            bt  = ov && out_ready;
            @(posedge clk);
            if (bt && exp_q.size() > 0) exp_q.pop_front();
            if (acc) push_word(in_data, in_high, width);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 40000 || exp_q.size() != 0)
            begin errors++; $display("FAIL rand%0d_drain cycles=%0d left=%0d required <40000 0", width, cyc, exp_q.size()); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel13 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_order();
        test_stall();
        test_back_to_back();
        test_reset_midword();
        test_random(32, 1500, 1'b0);
        test_random(13, 2000, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
